// File: rtl/memory_access_controller.sv
// memory_access_controller: single-outstanding load/store initiator for the
// ROM/RAM memory system. Accepts one request, drives Address/Write_Enable/
// Write_Data for one ACCESS cycle, waits the region read latency, then holds
// the response until the requester consumes it.
// Optional feature macro: ALIGN_CHECK_EN (misaligned word access -> error).
module memory_access_controller #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE    = 32'h1001_0000,
    parameter int                    ROM_LATENCY = 0,
    parameter int                    RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [ADDR_WIDTH-1:0] Address_o,
    output logic                  Write_Enable_o,
    output logic [DATA_WIDTH-1:0] Write_Data_o,
    input  logic [DATA_WIDTH-1:0] Instruction_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t                state, state_n;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [3:0]            cnt;

    logic                  is_ram;
    logic [3:0]            lat;
    logic                  misalign;
    logic                  acc_err;
    logic                  accept;

    assign is_ram = (addr_q >= RAM_BASE);
    assign lat    = is_ram ? 4'(RAM_LATENCY) : 4'(ROM_LATENCY);

`ifdef ALIGN_CHECK_EN
    assign misalign = (addr_q[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Stores into ROM and misaligned accesses complete with an error, no write.
    assign acc_err = (we_q & ~is_ram) | misalign;

    assign req_ready_o    = (state == IDLE) & ~reset;
    assign accept         = req_valid_i & req_ready_o;
    assign rsp_valid_o    = (state == RESP);
    assign rsp_rdata_o    = rdata_q;
    assign rsp_err_o      = err_q;
    // Address/data come straight from the request registers so they hold in IDLE.
    assign Address_o      = addr_q;
    assign Write_Data_o   = wdata_q;
    assign Write_Enable_o = (state == ACCESS) & we_q & ~acc_err;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = ACCESS;
            ACCESS:  if (we_q || acc_err || lat == 4'd0) state_n = RESP;
                     else                                state_n = WAIT;
            WAIT:    if (cnt <= 4'd1) state_n = RESP;
            RESP:    if (rsp_ready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request capture, latency counter and response data.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                    end
                end
                ACCESS: begin
                    err_q <= acc_err;
                    if (we_q || acc_err)  rdata_q <= '0;
                    else if (lat == 4'd0) rdata_q <= Instruction_i;
                    else                  cnt     <= lat;
                end
                WAIT: begin
                    if (cnt <= 4'd1) begin
                        rdata_q <= Instruction_i;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed bench for memory_access_controller with a small ROM (combinational)
// and RAM (one-cycle registered read) model. Expected values are hand-computed.
module tb_memory_access_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready_o, rsp_valid_o, rsp_err_o, Write_Enable_o;
    logic [31:0] rsp_rdata_o, Address_o, Write_Data_o, Instruction_i;

    int n_chk  = 0;
    int n_pass = 0;

    memory_access_controller dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .Address_o      (Address_o),
        .Write_Enable_o (Write_Enable_o),
        .Write_Data_o   (Write_Data_o),
        .Instruction_i  (Instruction_i)
    );

    always #5 clk = ~clk;

    // Memory model: ROM word i = A000_000i, RAM preloaded with 5000_000i.
    logic [31:0] ram [16];
    logic [31:0] ram_rd_q;

    initial for (int i = 0; i < 16; i++) ram[i] = 32'h5000_0000 + i;

    always @(posedge clk) begin
        ram_rd_q <= ram[Address_o[5:2]];
        if (Write_Enable_o) ram[Address_o[5:2]] <= Write_Data_o;
    end

    assign Instruction_i = (Address_o >= 32'h1001_0000) ? ram_rd_q
                                                        : (32'hA000_0000 | {28'd0, Address_o[5:2]});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request/response; checks latency, data, error, write pulses and
    // response stability while rsp_ready is held low for 'hold' cycles.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold, input int exp_lat,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_we);
        int cyc;
        int wecnt;
        wecnt = 0;
        chk({tag, "_req_ready"}, {31'd0, req_ready_o}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0; req_we = 1'b0;
        cyc = 1;
        while (!rsp_valid_o && cyc < 40) begin
            if (Write_Enable_o) wecnt++;
            tick();
            cyc++;
        end
        if (!rsp_valid_o) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_lat"},   cyc,                      exp_lat);
            chk({tag, "_rdata"}, rsp_rdata_o,              exp_rdata);
            chk({tag, "_err"},   {31'd0, rsp_err_o},       {31'd0, exp_err});
            chk({tag, "_we"},    wecnt,                    exp_we);
            for (int i = 0; i < hold; i++) begin
                tick();
                chk({tag, "_hold_valid"}, {31'd0, rsp_valid_o}, 32'd1);
                chk({tag, "_hold_rdata"}, rsp_rdata_o,          exp_rdata);
                chk({tag, "_hold_ready"}, {31'd0, req_ready_o}, 32'd0);
                chk({tag, "_hold_we"},    {31'd0, Write_Enable_o}, 32'd0);
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk({tag, "_rsp_done"}, {31'd0, rsp_valid_o}, 32'd0);
        end
    endtask

    initial begin
        int seen;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
        req_addr = '0; req_wdata = '0;
        tick(); tick();
        chk("rst_req_ready", {31'd0, req_ready_o},    32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o},    32'd0);
        chk("rst_we",        {31'd0, Write_Enable_o}, 32'd0);
        chk("rst_addr",      Address_o,               32'd0);
        chk("rst_wdata",     Write_Data_o,            32'd0);
        reset = 1'b0;
        tick();

        txn("rom_ld4",   1'b0, 32'h0000_0004, 32'h0,         0, 2, 32'hA000_0001, 1'b0, 0);
        txn("ram_st8",   1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 0, 2, 32'h0,         1'b0, 1);
        txn("ram_ld8",   1'b0, 32'h1001_0008, 32'h0,         0, 3, 32'hDEAD_BEEF, 1'b0, 0);
        chk("idle_addr_hold", Address_o, 32'h1001_0008);
        txn("rom_st10",  1'b1, 32'h0000_0010, 32'h0000_1234, 0, 2, 32'h0,         1'b1, 0);
        txn("rom_hold",  1'b0, 32'h0000_000C, 32'h0,         5, 2, 32'hA000_0003, 1'b0, 0);
        txn("rom_top",   1'b0, 32'h1000_FFFC, 32'h0,         0, 2, 32'hA000_000F, 1'b0, 0);
        txn("ram_base",  1'b0, 32'h1001_0000, 32'h0,         0, 3, 32'h5000_0000, 1'b0, 0);
        txn("ram_st0",   1'b1, 32'h1001_0000, 32'h1122_3344, 0, 2, 32'h0,         1'b0, 1);
`ifdef ALIGN_CHECK_EN
        txn("misalign",  1'b0, 32'h1001_0002, 32'h0,         0, 2, 32'h0,         1'b1, 0);
`else
        txn("misalign",  1'b0, 32'h1001_0002, 32'h0,         0, 3, 32'h1122_3344, 1'b0, 0);
`endif

        // Reset while a RAM load is in WAIT: transaction must vanish.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1001_0004;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        chk("rstw_ready_low", {31'd0, req_ready_o}, 32'd0);
        tick();
        chk("rstw_rsp_valid", {31'd0, rsp_valid_o},    32'd0);
        chk("rstw_we",        {31'd0, Write_Enable_o}, 32'd0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid_o || Write_Enable_o) seen++;
            tick();
        end
        rsp_ready = 1'b0;
        chk("rstw_no_rsp",   seen,                  32'd0);
        chk("rstw_ready_up", {31'd0, req_ready_o},  32'd1);

        // Controller still usable afterwards.
        txn("post_rst",  1'b0, 32'h1001_0008, 32'h0,         0, 3, 32'hDEAD_BEEF, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
